// File: rtl/rx_frame_unpack.sv
// Unpacks receiver frames (interleaved i/q/iq3 samples, 48-bit ticks, buffer counter) from the rx buffer.
// Optional buffer-counter continuity check enabled by defining RX_FRAME_CTR_CHECK_EN.
module rx_frame_unpack #(
    parameter int V_RX_CHANS = 4,
    parameter int PEND_W     = 4
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [7:0]  nrx_samps,
    input  logic        frame_avail,
    output logic        rx_rd,
    input  logic [15:0] rx_dout,
    output logic        samp_valid,
    input  logic        samp_ready,
    output logic [3:0]  samp_chan,
    output logic [1:0]  samp_sel,
    output logic [15:0] samp_data,
    output logic [47:0] ticks,
    output logic        ticks_valid,
    output logic [15:0] buf_ctr,
    output logic        frame_done,
    output logic        busy,
    output logic        pend_ovf,
    output logic        ctr_err,
    output logic [1:0]  fsm_state
);

    // Handshake: a sample word moves on any cycle where samp_valid && samp_ready; while
    // samp_valid is high and samp_ready is low, samp_data/chan/sel are held and no read is issued.
    typedef enum logic [1:0] {IDLE, REQ, CAP, PRESENT} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [3:0]        CHAN_LAST = 4'(V_RX_CHANS - 1);

    state_t            state, state_next;
    logic [PEND_W-1:0] pend;
    logic [7:0]        n_lat, samp_idx;
    logic [3:0]        chan_idx;
    logic [1:0]        sel_idx, trail_idx;
    logic              in_trailer;
    logic [31:0]       ticks_hold;
    logic              frame_start, xfer, cap_samp, cap_trail;

    assign rx_rd      = (state == REQ);
    assign samp_valid = (state == PRESENT);
    assign busy       = (state != IDLE);
    assign fsm_state  = state;
    assign xfer       = (state == PRESENT) && samp_ready;
    assign cap_samp   = (state == CAP) && !in_trailer;
    assign cap_trail  = (state == CAP) && in_trailer;

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (pend != '0) begin
                    state_next  = REQ;
                    frame_start = 1'b1;
                end
            end
            REQ: state_next = CAP;
            CAP: begin
                if (!in_trailer)            state_next = PRESENT;
                else if (trail_idx == 2'd3) state_next = IDLE;
                else                        state_next = REQ;
            end
            PRESENT: if (samp_ready) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    // A frame_avail coinciding with a frame start always fits, even when the counter is full.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            pend_ovf <= 1'b0;
        end else if (frame_avail && !frame_start) begin
            if (pend == PEND_MAX) pend_ovf <= 1'b1;
            else                  pend     <= pend + 1'b1;
        end else if (!frame_avail && frame_start) begin
            pend <= pend - 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            n_lat       <= '0;
            samp_idx    <= '0;
            chan_idx    <= '0;
            sel_idx     <= '0;
            trail_idx   <= '0;
            in_trailer  <= 1'b0;
            samp_data   <= '0;
            samp_chan   <= '0;
            samp_sel    <= '0;
            ticks_hold  <= '0;
            ticks       <= '0;
            ticks_valid <= 1'b0;
            buf_ctr     <= '0;
            frame_done  <= 1'b0;
        end else begin
            ticks_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (frame_start) begin
                n_lat      <= nrx_samps;
                samp_idx   <= '0;
                chan_idx   <= '0;
                sel_idx    <= '0;
                trail_idx  <= '0;
                in_trailer <= (nrx_samps == 8'd0);
            end
            if (cap_samp) begin
                samp_data <= rx_dout;
                samp_chan <= chan_idx;
                samp_sel  <= sel_idx;
            end
            // sel runs fastest, then channel, then sample count
            if (xfer) begin
                if (sel_idx == 2'd2) begin
                    sel_idx <= 2'd0;
                    if (chan_idx == CHAN_LAST) begin
                        chan_idx <= '0;
                        if (samp_idx == n_lat - 8'd1) in_trailer <= 1'b1;
                        else                          samp_idx   <= samp_idx + 8'd1;
                    end else begin
                        chan_idx <= chan_idx + 4'd1;
                    end
                end else begin
                    sel_idx <= sel_idx + 2'd1;
                end
            end
            if (cap_trail) begin
                trail_idx <= trail_idx + 2'd1;
                case (trail_idx)
                    2'd0: ticks_hold[15:0]  <= rx_dout;
                    2'd1: ticks_hold[31:16] <= rx_dout;
                    2'd2: begin
                        ticks       <= {rx_dout, ticks_hold};
                        ticks_valid <= 1'b1;
                    end
                    default: begin
                        buf_ctr    <= rx_dout;
                        frame_done <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef RX_FRAME_CTR_CHECK_EN
    logic first_frame;

    // The first counter word after reset has no predecessor and is never flagged.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            first_frame <= 1'b1;
            ctr_err     <= 1'b0;
        end else if (cap_trail && trail_idx == 2'd3) begin
            first_frame <= 1'b0;
            if (!first_frame && rx_dout != buf_ctr + 16'd1) ctr_err <= 1'b1;
        end
    end
`else
    assign ctr_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_unpack.sv
// Directed self-checking bench for rx_frame_unpack with a behavioural rx buffer model.
// Follows RX_FRAME_CTR_CHECK_EN so the counter-check expectation matches the build.
module tb_rx_frame_unpack;
    localparam int C = 4;

    logic        cpu_clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  nrx_samps = '0;
    logic        frame_avail = 1'b0;
    logic        rx_rd;
    logic [15:0] rx_dout = '0;
    logic        samp_valid;
    logic        samp_ready = 1'b0;
    logic [3:0]  samp_chan;
    logic [1:0]  samp_sel;
    logic [15:0] samp_data;
    logic [47:0] ticks;
    logic        ticks_valid;
    logic [15:0] buf_ctr;
    logic        frame_done;
    logic        busy;
    logic        pend_ovf;
    logic        ctr_err;
    logic [1:0]  fsm_state;

    logic [15:0] buf_q[$];
    logic [21:0] exp_q[$];
    logic [21:0] obs_q[$];
    int assertions = 0;
    int failures = 0;
    int rd_cnt, fd_cnt, tv_cnt, sv_cnt, busy_cnt;

    always #5 cpu_clk = ~cpu_clk;

    rx_frame_unpack #(.V_RX_CHANS(C), .PEND_W(4)) dut (
        .cpu_clk(cpu_clk), .reset(reset), .nrx_samps(nrx_samps), .frame_avail(frame_avail),
        .rx_rd(rx_rd), .rx_dout(rx_dout), .samp_valid(samp_valid), .samp_ready(samp_ready),
        .samp_chan(samp_chan), .samp_sel(samp_sel), .samp_data(samp_data), .ticks(ticks),
        .ticks_valid(ticks_valid), .buf_ctr(buf_ctr), .frame_done(frame_done), .busy(busy),
        .pend_ovf(pend_ovf), .ctr_err(ctr_err), .fsm_state(fsm_state)
    );

    // rx buffer: data appears one cycle after the read strobe
    always @(posedge cpu_clk) begin
        if (rx_rd) begin
            if (buf_q.size() > 0) rx_dout <= buf_q.pop_front();
            else                  rx_dout <= 16'hDEAD;
        end
    end

    always @(negedge cpu_clk) begin
        if (!reset) begin
            if (rx_rd)       rd_cnt++;
            if (frame_done)  fd_cnt++;
            if (ticks_valid) tv_cnt++;
            if (samp_valid)  sv_cnt++;
            if (busy)        busy_cnt++;
            if (samp_valid && samp_ready) obs_q.push_back({samp_chan, samp_sel, samp_data});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cpu_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rd_cnt = 0; fd_cnt = 0; tv_cnt = 0; sv_cnt = 0; busy_cnt = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_avail();
        frame_avail = 1'b1;
        tick(1);
        frame_avail = 1'b0;
    endtask

    task automatic wait_fd(input int n, input int budget);
        for (int i = 0; i < budget && fd_cnt < n; i++) tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        buf_q.delete();
        clear_mon();
        tick(1);
    endtask

    task automatic load_frame(input int n, input logic [15:0] base, input logic [15:0] t0,
                              input logic [15:0] t1, input logic [15:0] t2, input logic [15:0] ctr);
        for (int k = 0; k < 3 * n * C; k++) begin
            logic [15:0] d;
            d = base + 16'(k);
            buf_q.push_back(d);
            exp_q.push_back({4'((k / 3) % C), 2'(k % 3), d});
        end
        buf_q.push_back(t0);
        buf_q.push_back(t1);
        buf_q.push_back(t2);
        buf_q.push_back(ctr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        assertions++;
        if ({rx_rd, samp_valid, ticks_valid, frame_done, busy, pend_ovf, ctr_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b exp 0", {rx_rd, samp_valid, ticks_valid, frame_done, busy, pend_ovf, ctr_err});
        end
        assertions++;
        if ({samp_chan, samp_sel, samp_data} !== 22'h0) begin
            failures++; $display("FAIL reset_samp got %h exp 0", {samp_chan, samp_sel, samp_data});
        end
        assertions++;
        if (ticks !== 48'h0) begin failures++; $display("FAIL reset_ticks got %h exp 0", ticks); end
        assertions++;
        if (buf_ctr !== 16'h0) begin failures++; $display("FAIL reset_buf_ctr got %h exp 0", buf_ctr); end
        assertions++;
        if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
        reset = 1'b0;
        clear_mon();
        tick(2);
    endtask

    task automatic test_frame();
        clear_mon();
        nrx_samps = 8'd2;
        samp_ready = 1'b1;
        load_frame(2, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 16'h0005);
        pulse_avail();
        wait_fd(1, 300);
        tick(3);
        assertions++;
        if (obs_q.size() != 24) begin failures++; $display("FAIL frame_nwords got %0d exp 24", obs_q.size()); end
        for (int i = 0; i < 24; i++) begin
            logic [21:0] got;
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            assertions++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL frame_word%0d got %h exp %h", i, got, exp_q[i]); end
        end
        assertions++;
        if (rd_cnt != 28) begin failures++; $display("FAIL frame_rx_rd got %0d exp 28", rd_cnt); end
        assertions++;
        if (fd_cnt != 1) begin failures++; $display("FAIL frame_done_cnt got %0d exp 1", fd_cnt); end
        assertions++;
        if (tv_cnt != 1) begin failures++; $display("FAIL frame_ticks_valid got %0d exp 1", tv_cnt); end
        assertions++;
        if (ticks !== 48'h333322221111) begin failures++; $display("FAIL frame_ticks got %h exp 333322221111", ticks); end
        assertions++;
        if (buf_ctr !== 16'h0005) begin failures++; $display("FAIL frame_buf_ctr got %h exp 0005", buf_ctr); end
        // 24 sample words at 3 cycles plus 4 trailer words at 2 cycles
        assertions++;
        if (busy_cnt != 80) begin failures++; $display("FAIL frame_busy_cycles got %0d exp 80", busy_cnt); end
    endtask

    task automatic test_stall();
        logic [21:0] snap;
        int bad;
        clear_mon();
        nrx_samps = 8'd2;
        samp_ready = 1'b1;
        load_frame(2, 16'h0200, 16'h4444, 16'h5555, 16'h6666, 16'h0006);
        pulse_avail();
        for (int i = 0; i < 200 && obs_q.size() < 5; i++) tick(1);
        samp_ready = 1'b0;
        tick(2);
        snap = {samp_chan, samp_sel, samp_data};
        assertions++;
        if (!samp_valid || snap !== {4'd1, 2'd2, 16'h0205}) begin
            failures++; $display("FAIL stall_word5 got v=%b %h exp v=1 %h", samp_valid, snap, {4'd1, 2'd2, 16'h0205});
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (rx_rd || !samp_valid || {samp_chan, samp_sel, samp_data} !== snap) bad++;
        end
        assertions++;
        if (bad != 0) begin failures++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad); end
        samp_ready = 1'b1;
        wait_fd(1, 300);
        tick(2);
        assertions++;
        if (obs_q.size() != 24) begin failures++; $display("FAIL stall_nwords got %0d exp 24", obs_q.size()); end
        for (int i = 0; i < 24; i++) begin
            logic [21:0] got;
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            assertions++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL stall_word%0d got %h exp %h", i, got, exp_q[i]); end
        end
        assertions++;
        if (rd_cnt != 28) begin failures++; $display("FAIL stall_rx_rd got %0d exp 28", rd_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        nrx_samps = 8'd1;
        samp_ready = 1'b1;
        load_frame(1, 16'h0300, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0007);
        load_frame(0, 16'h0000, 16'h0B01, 16'h0B02, 16'h0B03, 16'h0008);
        pulse_avail();
        pulse_avail();
        nrx_samps = 8'd0;   // first frame already latched 1
        for (int i = 0; i < 200 && !frame_done; i++) tick(1);
        tick(1);
        assertions++;
        if (!(busy === 1'b1 && rx_rd === 1'b1)) begin
            failures++; $display("FAIL b2b_restart got busy=%b rx_rd=%b exp 1 1", busy, rx_rd);
        end
        wait_fd(2, 200);
        tick(2);
        assertions++;
        if (fd_cnt != 2) begin failures++; $display("FAIL b2b_done_cnt got %0d exp 2", fd_cnt); end
        assertions++;
        if (sv_cnt != 12 || obs_q.size() != 12) begin
            failures++; $display("FAIL b2b_samples got %0d/%0d exp 12", sv_cnt, obs_q.size());
        end
        for (int i = 0; i < 12; i++) begin
            logic [21:0] got;
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            assertions++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL b2b_word%0d got %h exp %h", i, got, exp_q[i]); end
        end
        assertions++;
        if (rd_cnt != 20) begin failures++; $display("FAIL b2b_rx_rd got %0d exp 20", rd_cnt); end
        assertions++;
        if (tv_cnt != 2) begin failures++; $display("FAIL b2b_ticks_valid got %0d exp 2", tv_cnt); end
        assertions++;
        if (ticks !== 48'h0B030B020B01 || buf_ctr !== 16'h0008) begin
            failures++; $display("FAIL b2b_zero_frame got %h/%h exp 0b030b020b01/0008", ticks, buf_ctr);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        nrx_samps = 8'd1;
        samp_ready = 1'b0;
        load_frame(1, 16'h0400, 16'h0C01, 16'h0C02, 16'h0C03, 16'h0010);
        for (int i = 0; i < 15; i++) load_frame(0, 16'h0000, 16'h0D01, 16'h0D02, 16'h0D03, 16'h0011 + 16'(i));
        pulse_avail();
        for (int i = 0; i < 20 && !samp_valid; i++) tick(1);
        for (int i = 0; i < 15; i++) begin
            pulse_avail();
            tick(1);
        end
        assertions++;
        if (pend_ovf !== 1'b0) begin failures++; $display("FAIL ovf_at_max got %b exp 0", pend_ovf); end
        pulse_avail();
        assertions++;
        if (pend_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got %b exp 1", pend_ovf); end
        nrx_samps = 8'd0;
        samp_ready = 1'b1;
        wait_fd(16, 2000);
        tick(20);
        assertions++;
        if (fd_cnt - 1 != 15) begin failures++; $display("FAIL ovf_queued_frames got %0d exp 15", fd_cnt - 1); end
        assertions++;
        if (rd_cnt != 76 || busy !== 1'b0) begin
            failures++; $display("FAIL ovf_drain got rd=%0d busy=%b exp 76 0", rd_cnt, busy);
        end
        assertions++;
        if (pend_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b exp 1", pend_ovf); end
    endtask

    task automatic test_ctr_check();
        logic exp_err;
`ifdef RX_FRAME_CTR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        nrx_samps = 8'd0;
        samp_ready = 1'b1;
        load_frame(0, 16'h0000, 16'h0E01, 16'h0E02, 16'h0E03, 16'hFFFF);
        load_frame(0, 16'h0000, 16'h0E04, 16'h0E05, 16'h0E06, 16'h0000);
        load_frame(0, 16'h0000, 16'h0E07, 16'h0E08, 16'h0E09, 16'h0002);
        pulse_avail();
        wait_fd(1, 100);
        pulse_avail();
        wait_fd(2, 100);
        tick(1);
        assertions++;
        if (ctr_err !== 1'b0 || buf_ctr !== 16'h0000) begin
            failures++; $display("FAIL ctr_wrap got err=%b ctr=%h exp 0 0000", ctr_err, buf_ctr);
        end
        pulse_avail();
        wait_fd(3, 100);
        tick(1);
        assertions++;
        if (ctr_err !== exp_err || buf_ctr !== 16'h0002) begin
            failures++; $display("FAIL ctr_gap got err=%b ctr=%h exp %b 0002", ctr_err, buf_ctr, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        nrx_samps = 8'd2;
        samp_ready = 1'b1;
        load_frame(2, 16'h0500, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0042);
        pulse_avail();
        for (int i = 0; i < 100 && obs_q.size() < 3; i++) tick(1);
        reset = 1'b1;
        #1;
        assertions++;
        if ({rx_rd, samp_valid, busy, ticks_valid, frame_done, fsm_state} !== 7'b0) begin
            failures++; $display("FAIL rstmid_ctrl got %b exp 0", {rx_rd, samp_valid, busy, ticks_valid, frame_done, fsm_state});
        end
        assertions++;
        if ({samp_chan, samp_sel, samp_data} !== 22'h0 || ticks !== 48'h0 || buf_ctr !== 16'h0) begin
            failures++; $display("FAIL rstmid_data got %h %h %h exp 0", {samp_chan, samp_sel, samp_data}, ticks, buf_ctr);
        end
        tick(2);
        reset = 1'b0;
        buf_q.delete();
        clear_mon();
        tick(20);
        assertions++;
        if (ticks !== 48'h0 || buf_ctr !== 16'h0 || fd_cnt != 0 || tv_cnt != 0) begin
            failures++; $display("FAIL rstmid_abandon got %h %h fd=%0d tv=%0d exp 0", ticks, buf_ctr, fd_cnt, tv_cnt);
        end
        nrx_samps = 8'd1;
        load_frame(1, 16'h0600, 16'h1234, 16'h5678, 16'h9ABC, 16'h0099);
        pulse_avail();
        wait_fd(1, 200);
        tick(2);
        assertions++;
        if (obs_q.size() != 12) begin failures++; $display("FAIL rstmid_nwords got %0d exp 12", obs_q.size()); end
        for (int i = 0; i < 12; i++) begin
            logic [21:0] got;
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            assertions++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL rstmid_word%0d got %h exp %h", i, got, exp_q[i]); end
        end
        assertions++;
        if (ticks !== 48'h9ABC56781234 || buf_ctr !== 16'h0099) begin
            failures++; $display("FAIL rstmid_trailer got %h/%h exp 9abc56781234/0099", ticks, buf_ctr);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_ctr_check();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/rx_frame_unpack.md
RX_FRAME_UNPACK -- requirements
Module: rx_frame_unpack

Interface
REQ-001 Parameter V_RX_CHANS, default from kiwi.gen.vh, number of interleaved receiver channels (1..16).
REQ-002 Parameter PEND_W, default 4, width of pending-frame counter.
REQ-003 cpu_clk  in  1  sole clock, all logic posedge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 nrx_samps  in  8  samples per channel per frame, sampled at frame start.
REQ-006 frame_avail  in  1  one-cycle pulse per complete frame in rx buffer.
REQ-007 rx_rd  out  1  one-cycle buffer read strobe.
REQ-008 rx_dout  in  16  buffer data, valid exactly 1 cycle after rx_rd.
REQ-009 samp_valid / samp_ready  out/in  1/1  output handshake, transfer when both high.
REQ-010 samp_chan  out  4  channel of presented word; samp_sel  out  2  0=i, 1=q, 2=iq3; samp_data  out  16.
REQ-011 ticks  out  48, ticks_valid  out  1 (one-cycle pulse); buf_ctr  out  16; frame_done  out  1 (pulse).
REQ-012 busy  out  1; pend_ovf  out  1 sticky; ctr_err  out  1 sticky.

Function
REQ-013 Frame = nrx_samps x V_RX_CHANS x {i,q,iq3} words, then 3 ticks words (bits 15:0, 31:16, 47:32), then 1 buf_ctr word; total 3*N*C+4 words.
REQ-014 Pending counter: +1 on frame_avail, -1 on frame start, both same cycle = unchanged; at max value a further frame_avail is dropped and sets pend_ovf.
REQ-015 FSM states IDLE, REQ, CAP, PRESENT; IDLE->REQ when pending>0 (latch nrx_samps, clear indices, busy=1).
REQ-016 REQ: assert rx_rd one cycle -> CAP; CAP: capture rx_dout -> PRESENT if sample word, else process ticks/ctr word and go to REQ or IDLE.
REQ-017 PRESENT: samp_valid=1 with data/chan/sel stable until samp_ready; on transfer advance indices -> REQ next cycle; max one outstanding read.
REQ-018 Index order: sel fastest (0,1,2), then channel 0..V_RX_CHANS-1, then sample count 0..nrx_samps-1.
REQ-019 Ticks words assembled into holding register; ticks updated and ticks_valid pulsed the cycle after third ticks word captured.
REQ-020 Counter word: buf_ctr updated, frame_done pulsed same cycle, busy drops, FSM -> IDLE.
REQ-021 nrx_samps=0: frame is 4 words only, no samp_valid.
REQ-022 Back-to-back frames: IDLE->REQ on the cycle after frame_done if pending>0; at most 1 idle cycle.
REQ-023 Change of nrx_samps mid-frame has no effect until next frame start.
REQ-024 Minimum per-word cost 3 cycles with samp_ready held high.

Reset
REQ-025 On reset: FSM IDLE, pending=0, all indices 0, rx_rd=0, samp_valid=0, ticks_valid=0, frame_done=0, busy=0.
REQ-026 Reset: samp_data=0, samp_chan=0, samp_sel=0, ticks=0, buf_ctr=0, pend_ovf=0, ctr_err=0, first-frame flag set.
REQ-027 Reset mid-frame abandons frame; no partial ticks/buf_ctr update afterwards.

Configuration
REQ-028 Macro RX_FRAME_CTR_CHECK_EN defined: each buf_ctr word except the first after reset compared to previous+1 mod 2^16; mismatch sets ctr_err sticky until reset; 0xFFFF->0x0000 is valid.
REQ-029 Macro undefined: ctr_err tied 0, no comparison logic; buf_ctr still captured.

Verification
REQ-030 C=4, nrx_samps=2, one frame_avail, ready=1 -> 24 samp_valid transfers in order, ticks_valid once, frame_done once, 28 rx_rd total.
REQ-031 Ticks words 0x1111,0x2222,0x3333 -> ticks=0x333322221111 with ticks_valid pulse.
REQ-032 samp_ready low 10 cycles on word 5 -> samp_data/chan/sel stable, no rx_rd during stall, sequence resumes intact.
REQ-033 frame_avail pulsed 16 times with PEND_W=4 and FSM stalled -> pend_ovf=1, exactly 15 frames processed.
REQ-034 CHECK_EN, counters 0xFFFF,0x0000,0x0002 -> ctr_err 0 after second frame, 1 after third.
REQ-035 reset asserted mid-sample phase -> outputs per REQ-025/026 immediately, next frame decoded correctly.
